// File: rtl/top_if.sv
// Game I/O bundle for the Minesweeper core: buttons, mine-map write port,
// game-over flag and raster pixel.
interface top_if;
   logic       mark;
   logic       tap;
   logic       left_button;
   logic       right_button;
   logic       up_button;
   logic       down_button;
   logic       D;
   logic       WE;
   logic [7:0] write;
   logic       dead;
   logic       rgb;

   // Driver side: buttons and mine loader.
   modport master (
      output mark, tap, left_button, right_button, up_button, down_button,
      output D, WE, write,
      input  dead, rgb
   );

   // Game core side.
   modport slave (
      input  mark, tap, left_button, right_button, up_button, down_button,
      input  D, WE, write,
      output dead, rgb
   );
endinterface

// File: rtl/top.sv
// 16x16 Minesweeper core: mine map, revealed/flag state, cursor,
// button edge detection and a one-cell-per-clock raster stream.
module top (
   input  logic  clk,
   input  logic  rst,
   top_if.slave  bus
);

   logic [255:0] mine_r;
   logic [255:0] revealed_r;
   logic [255:0] flag_r;
   logic [3:0]   row_r;
   logic [3:0]   col_r;
   logic         dead_r;
   logic [7:0]   scan_r;

   logic         mark_q_r;
   logic         tap_q_r;
   logic         left_q_r;
   logic         right_q_r;
   logic         up_q_r;
   logic         down_q_r;

   logic         mark_ev_s;
   logic         tap_ev_s;
   logic         left_ev_s;
   logic         right_ev_s;
   logic         up_ev_s;
   logic         down_ev_s;
   logic [7:0]   cur_s;
   logic [3:0]   col_next_s;
   logic [3:0]   row_next_s;

   assign mark_ev_s  = bus.mark         & ~mark_q_r;
   assign tap_ev_s   = bus.tap          & ~tap_q_r;
   assign left_ev_s  = bus.left_button  & ~left_q_r;
   assign right_ev_s = bus.right_button & ~right_q_r;
   assign up_ev_s    = bus.up_button    & ~up_q_r;
   assign down_ev_s  = bus.down_button  & ~down_q_r;

   // Cell under the cursor before any move applied this cycle.
   assign cur_s = {row_r, col_r};

   // Next cursor position; opposing events on the same axis cancel out.
   always_comb begin
      col_next_s = col_r;
      row_next_s = row_r;
      case ({left_ev_s, right_ev_s})
         2'b10:   col_next_s = col_r - 4'd1;
         2'b01:   col_next_s = col_r + 4'd1;
         default: col_next_s = col_r;
      endcase
      case ({up_ev_s, down_ev_s})
         2'b10:   row_next_s = row_r - 4'd1;
         2'b01:   row_next_s = row_r + 4'd1;
         default: row_next_s = row_r;
      endcase
   end

   // Button history, scan counter, mine loading and game actions.
   always_ff @(posedge clk) begin
      if (rst) begin
         mine_r     <= 256'd0;
         revealed_r <= 256'd0;
         flag_r     <= 256'd0;
         row_r      <= 4'd0;
         col_r      <= 4'd0;
         dead_r     <= 1'b0;
         scan_r     <= 8'd0;
         mark_q_r   <= 1'b0;
         tap_q_r    <= 1'b0;
         left_q_r   <= 1'b0;
         right_q_r  <= 1'b0;
         up_q_r     <= 1'b0;
         down_q_r   <= 1'b0;
      end else begin
         mark_q_r  <= bus.mark;
         tap_q_r   <= bus.tap;
         left_q_r  <= bus.left_button;
         right_q_r <= bus.right_button;
         up_q_r    <= bus.up_button;
         down_q_r  <= bus.down_button;
         scan_r    <= scan_r + 8'd1;

         // The loader works regardless of game state; taps below see the
         // pre-write mine value because of non-blocking semantics.
         if (bus.WE) begin
            mine_r[bus.write] <= bus.D;
         end

         if (!dead_r) begin
            col_r <= col_next_s;
            row_r <= row_next_s;
            if (tap_ev_s) begin
               // Tap wins over a simultaneous mark.
               if (!flag_r[cur_s] && !revealed_r[cur_s]) begin
                  revealed_r[cur_s] <= 1'b1;
                  if (mine_r[cur_s]) begin
                     dead_r <= 1'b1;
                  end
               end
            end else if (mark_ev_s) begin
               if (!revealed_r[cur_s]) begin
                  flag_r[cur_s] <= ~flag_r[cur_s];
               end
            end
         end
      end
   end

   assign bus.dead = dead_r;
   assign bus.rgb  = (scan_r == cur_s) | revealed_r[scan_r] | (dead_r & mine_r[scan_r]);

endmodule

// File: tb/tb_top.sv
// Directed self-checking bench for the Minesweeper core.
module tb_top;

   logic clk;
   logic rst;
   int   errors;
   int   checks;
   logic [7:0] tb_scan;

   top_if bus ();

   top dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Advance one clock; sample point is 1 time unit after the rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
      tb_scan = tb_scan + 8'd1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      tb_scan = 8'd0;
   endtask

   task automatic pulse_right();
      bus.right_button = 1'b1; tick(); bus.right_button = 1'b0; tick();
   endtask

   task automatic pulse_left();
      bus.left_button = 1'b1; tick(); bus.left_button = 1'b0; tick();
   endtask

   task automatic pulse_up();
      bus.up_button = 1'b1; tick(); bus.up_button = 1'b0; tick();
   endtask

   task automatic pulse_down();
      bus.down_button = 1'b1; tick(); bus.down_button = 1'b0; tick();
   endtask

   task automatic pulse_mark();
      bus.mark = 1'b1; tick(); bus.mark = 1'b0; tick();
   endtask

   task automatic pulse_tap();
      bus.tap = 1'b1; tick(); bus.tap = 1'b0; tick();
   endtask

   task automatic load_mine(input logic [7:0] addr, input logic val);
      bus.WE = 1'b1; bus.write = addr; bus.D = val;
      tick();
      bus.WE = 1'b0; bus.D = 1'b0; bus.write = 8'd0;
   endtask

   // Watch one full raster pass; expect exactly one lit cell at exp_pos.
   task automatic scan_pass(input string tag, input logic [7:0] exp_pos);
      int cnt;
      logic [7:0] pos;
      cnt = 0;
      pos = 8'd0;
      for (int i = 0; i < 256; i++) begin
         if (bus.rgb) begin
            cnt++;
            pos = tb_scan;
         end
         tick();
      end
      chk({tag, "_count"}, cnt, 32'd1);
      chk({tag, "_pos"}, {24'd0, pos}, {24'd0, exp_pos});
   endtask

   initial begin
      errors = 0;
      checks = 0;
      tb_scan = 8'd0;
      rst = 1'b0;
      bus.mark = 1'b0; bus.tap = 1'b0;
      bus.left_button = 1'b0; bus.right_button = 1'b0;
      bus.up_button = 1'b0; bus.down_button = 1'b0;
      bus.D = 1'b0; bus.WE = 1'b0; bus.write = 8'd0;

      // Reset state and idle raster.
      do_reset();
      chk("rst_dead", {31'd0, bus.dead}, 32'd0);
      chk("rst_rgb", {31'd0, bus.rgb}, 32'd1);
      scan_pass("idle", 8'h00);

      // Mine at 0, tap -> dead on that edge; moves then frozen.
      load_mine(8'h00, 1'b1);
      bus.tap = 1'b1; tick();
      chk("tap_mine_dead", {31'd0, bus.dead}, 32'd1);
      chk("tap_mine_rev", {31'd0, dut.revealed_r[0]}, 32'd1);
      bus.tap = 1'b0; tick();
      pulse_right();
      chk("dead_no_move", {24'd0, dut.row_r, dut.col_r}, 32'h00);

      // Wrap-around: left then up from origin.
      do_reset();
      chk("rst_clears_dead", {31'd0, bus.dead}, 32'd0);
      pulse_left();
      pulse_up();
      chk("wrap_cursor", {24'd0, dut.row_r, dut.col_r}, 32'hFF);
      scan_pass("wrap", 8'hFF);

      // Opposing events cancel on each axis.
      bus.left_button = 1'b1; bus.right_button = 1'b1;
      bus.up_button = 1'b1; bus.down_button = 1'b1;
      tick();
      bus.left_button = 1'b0; bus.right_button = 1'b0;
      bus.up_button = 1'b0; bus.down_button = 1'b0;
      tick();
      chk("cancel_move", {24'd0, dut.row_r, dut.col_r}, 32'hFF);

      // Flag protects a mine; unflag and tap kills.
      do_reset();
      load_mine(8'h12, 1'b1);
      pulse_down();
      pulse_right();
      pulse_right();
      chk("cursor_12", {24'd0, dut.row_r, dut.col_r}, 32'h12);
      pulse_mark();
      chk("flag_set", {31'd0, dut.flag_r[8'h12]}, 32'd1);
      pulse_tap();
      chk("flag_blocks_tap", {31'd0, dut.revealed_r[8'h12]}, 32'd0);
      chk("flag_alive", {31'd0, bus.dead}, 32'd0);
      pulse_mark();
      chk("flag_clear", {31'd0, dut.flag_r[8'h12]}, 32'd0);
      pulse_tap();
      chk("unflag_dead", {31'd0, bus.dead}, 32'd1);
      scan_pass("dead_mine", 8'h12);

      // Mid-game reset with dead=1 and a concurrent mine write.
      rst = 1'b1; bus.WE = 1'b1; bus.write = 8'h40; bus.D = 1'b1;
      tick();
      chk("midrst_dead", {31'd0, bus.dead}, 32'd0);
      chk("midrst_mine", {31'd0, dut.mine_r[8'h40]}, 32'd0);
      chk("midrst_mine12", {31'd0, dut.mine_r[8'h12]}, 32'd0);
      chk("midrst_cursor", {24'd0, dut.row_r, dut.col_r}, 32'h00);
      rst = 1'b0; bus.WE = 1'b0; bus.D = 1'b0; bus.write = 8'd0;
      tb_scan = 8'd0;

      // Button held across reset release yields one event.
      bus.right_button = 1'b1;
      do_reset();
      tick();
      chk("held_rst_once", {28'd0, dut.col_r}, 32'd1);
      tick();
      tick();
      chk("held_no_repeat", {28'd0, dut.col_r}, 32'd1);
      bus.right_button = 1'b0;
      tick();

      // Hold tap on a safe cell for 10 cycles.
      bus.tap = 1'b1;
      for (int i = 0; i < 10; i++) tick();
      bus.tap = 1'b0;
      tick();
      chk("hold_tap_rev", {31'd0, dut.revealed_r[8'h01]}, 32'd1);
      chk("hold_tap_alive", {31'd0, bus.dead}, 32'd0);

      // Held mark toggles only once.
      pulse_right();
      bus.mark = 1'b1;
      for (int i = 0; i < 4; i++) tick();
      bus.mark = 1'b0;
      tick();
      chk("hold_mark_once", {31'd0, dut.flag_r[8'h02]}, 32'd1);

      // Tap and mark together: tap wins.
      pulse_right();
      bus.tap = 1'b1; bus.mark = 1'b1;
      tick();
      bus.tap = 1'b0; bus.mark = 1'b0;
      tick();
      chk("tapmark_rev", {31'd0, dut.revealed_r[8'h03]}, 32'd1);
      chk("tapmark_flag", {31'd0, dut.flag_r[8'h03]}, 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
